// File: rtl/img_pkg.sv
// Shared definitions for the bitmap pixel store: default geometry, pixel layout, writer FSM states.
package img_pkg;

    localparam int unsigned DEF_IMG_W = 48;
    localparam int unsigned DEF_IMG_H = 48;
    localparam int unsigned DEF_AW    = 12;
    localparam int unsigned CH_W      = 8;
    localparam int unsigned PIX_W     = 3 * CH_W;
    localparam int unsigned COORD_W   = 10;

    // Writer FSM: waiting for start of frame, then collecting R, G, B of each pixel.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GET_R = 2'd1,
        ST_GET_G = 2'd2,
        ST_GET_B = 2'd3
    } wr_state_e;

    // One packed 24-bit pixel as stored in the frame buffer.
    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } pixel_t;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port, no reset so it maps to block RAM.
module frame_ram #(
    parameter int unsigned DEPTH = 2304,
    parameter int unsigned AW    = 12,
    parameter int unsigned DW    = 24
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Read-before-write: a same-address read in the write cycle returns the old word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/image_writer.sv
// Writer side of the bitmap pixel store: packs an R,G,B byte stream into raster-order pixels
// and provides the registered (x,y) colour read port for the display path.
module image_writer
    import img_pkg::*;
#(
    parameter int unsigned IMG_W = DEF_IMG_W,
    parameter int unsigned IMG_H = DEF_IMG_H,
    parameter int unsigned AW    = DEF_AW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CH_W-1:0]    in_data,
    input  logic               in_sof,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [CH_W-1:0]    red,
    output logic [CH_W-1:0]    green,
    output logic [CH_W-1:0]    blue,
    output logic               frame_done,
    output logic               frame_valid
);

    localparam int unsigned NPIX    = IMG_W * IMG_H;
    localparam int unsigned LIN_W   = 2 * COORD_W;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

    wr_state_e       state_q;
    logic [CH_W-1:0] r_q;
    logic [CH_W-1:0] g_q;
    logic [AW-1:0]   wr_addr_q;
    logic [AW-1:0]   wr_addr_d;
    logic            in_ready_q;
    logic            frame_done_q;
    logic            frame_valid_q;
    logic            rd_in_range_q;

    logic            accept_c;
    logic            we_c;
    logic            last_pix_c;
    pixel_t          wr_pix_c;
    logic            rd_in_range_c;
    logic [LIN_W-1:0] rd_lin_c;
    logic [AW-1:0]   rd_addr_c;
    pixel_t          rd_pix;

    // Write-side handshake and the pixel write strobe (B byte without a frame restart).
    always_comb begin
        accept_c   = in_valid && in_ready_q;
        last_pix_c = (wr_addr_q == LAST_ADDR);
        we_c       = accept_c && !in_sof && (state_q == ST_GET_B);
        wr_pix_c   = '{r: r_q, g: g_q, b: in_data};
        wr_addr_d  = wr_addr_q + AW'(1);
    end

    // Writer FSM with R/G holding registers, raster address counter and frame status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            r_q           <= '0;
            g_q           <= '0;
            wr_addr_q     <= '0;
            in_ready_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            in_ready_q   <= 1'b1;
            frame_done_q <= 1'b0;
            if (accept_c) begin
                if (in_sof) begin
                    // Start (or restart) of a frame: this byte is R of pixel 0.
                    r_q           <= in_data;
                    wr_addr_q     <= '0;
                    frame_valid_q <= 1'b0;
                    state_q       <= ST_GET_G;
                end else begin
                    unique case (state_q)
                        ST_IDLE: begin
                            // Stray bytes outside a frame are dropped.
                        end
                        ST_GET_R: begin
                            r_q     <= in_data;
                            state_q <= ST_GET_G;
                        end
                        ST_GET_G: begin
                            g_q     <= in_data;
                            state_q <= ST_GET_B;
                        end
                        ST_GET_B: begin
                            if (last_pix_c) begin
                                frame_done_q  <= 1'b1;
                                frame_valid_q <= 1'b1;
                                wr_addr_q     <= '0;
                                state_q       <= ST_IDLE;
                            end else begin
                                wr_addr_q <= wr_addr_d;
                                state_q   <= ST_GET_R;
                            end
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    // Display coordinate to linear pixel address; out-of-image coordinates read address 0 and are masked.
    always_comb begin
        rd_in_range_c = (x < COORD_W'(IMG_W)) && (y < COORD_W'(IMG_H));
        rd_lin_c      = LIN_W'(y) * LIN_W'(IMG_W) + LIN_W'(x);
        rd_addr_c     = rd_in_range_c ? AW'(rd_lin_c) : '0;
    end

    // Range flag follows the RAM read by one cycle so the mask lines up with the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_in_range_q <= 1'b0;
        end else begin
            rd_in_range_q <= rd_in_range_c;
        end
    end

    frame_ram #(
        .DEPTH (NPIX),
        .AW    (AW),
        .DW    (PIX_W)
    ) u_frame_ram (
        .clk     (clk),
        .we_i    (we_c),
        .waddr_i (wr_addr_q),
        .wdata_i (wr_pix_c),
        .raddr_i (rd_addr_c),
        .rdata_o (rd_pix)
    );

    // Colour outputs: registered RAM word, forced to black when the coordinate was outside the image.
    always_comb begin
        red   = rd_in_range_q ? rd_pix.r : '0;
        green = rd_in_range_q ? rd_pix.g : '0;
        blue  = rd_in_range_q ? rd_pix.b : '0;
    end

    assign in_ready    = in_ready_q;
    assign frame_done  = frame_done_q;
    assign frame_valid = frame_valid_q;

endmodule
